// File: rtl/vga_timing_wb.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_wb
// Brief    : VGA timing and pattern generator with a Wishbone register slave.
//            Single clock; the pixel rate comes from a clock-enable divider.
//            Define VGA_SHADOW_EN to double-buffer the colour/box registers.
// Revision : 1.0
// ============================================================================
module vga_timing_wb #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 4,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_inta_o,
    output logic [COLOR_W-1:0] VGA_R_LED,
    output logic [COLOR_W-1:0] VGA_G_LED,
    output logic [COLOR_W-1:0] VGA_B_LED,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC
);

    localparam int c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_cw    = 3 * COLOR_W;
    // Counters are at least 12 bits so box bounds (X + SIZE) never overflow them
    localparam int c_hw    = ($clog2(c_h_tot) > 12) ? $clog2(c_h_tot) : 12;
    localparam int c_vw    = ($clog2(c_v_tot) > 12) ? $clog2(c_v_tot) : 12;
    localparam int c_dw    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bar_i = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
    localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_h_tot - 1);
    localparam logic [c_hw-1:0] c_h_act    = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_beg   = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_end   = c_hw'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_hw-1:0] c_bar_w    = c_hw'(c_bar_i);
    localparam logic [c_vw-1:0] c_v_last   = c_vw'(c_v_tot - 1);
    localparam logic [c_vw-1:0] c_v_act    = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_v_vb     = c_vw'(V_ACTIVE - 1);
    localparam logic [c_vw-1:0] c_vs_beg   = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_end   = c_vw'(V_ACTIVE + V_FP + V_SYNC);
    localparam bit              c_sync_off = !SYNC_POL;

    // Register file (software-visible copies)
    logic              r_en, r_irq_en, r_irq_pend, r_inta;
    logic [1:0]        r_mode;
    logic [c_cw-1:0]   r_bg, r_box_col;
    logic [10:0]       r_box_x, r_box_y;
    logic [7:0]        r_box_size;
    logic [15:0]       r_frame;
    logic              r_ack, r_err;
    logic [31:0]       r_dat;

    // Timing and pixel state
    logic [c_dw-1:0]   r_div;
    logic [c_hw-1:0]   r_h;
    logic [c_vw-1:0]   r_v;
    logic [COLOR_W-1:0] r_red, r_grn, r_blu;
    logic              r_hs, r_vs;

    // Set actually used to draw pixels
    logic [c_cw-1:0]   w_act_bg, w_act_box_col;
    logic [10:0]       w_act_x, w_act_y;
    logic [7:0]        w_act_size;

    logic              w_req, w_adr_ok, w_wr, w_w1c, w_vblank;
    logic [2:0]        w_idx;
    logic [31:0]       w_mask, w_cur, w_wdat;
    logic              w_pix_en, w_h_wrap, w_vb_start, w_active, w_in_box;
    logic              w_hs_on, w_vs_on;
    logic [c_hw-1:0]   w_bar, w_bx0, w_bx1;
    logic [2:0]        w_bar_idx;
    logic [c_vw-1:0]   w_by0, w_by1;
    logic [c_cw-1:0]   w_pix;
    logic              w_unused;

    assign w_unused = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0]};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_idx    = wb_adr_i[4:2];
    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_adr_ok = (w_idx <= 3'd5);
    assign w_wr     = w_req & wb_we_i & w_adr_ok;
    assign w_w1c    = wb_dat_i[1] & wb_sel_i[0];
    assign w_mask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_wdat   = (w_cur & ~w_mask) | (wb_dat_i & w_mask);
    assign w_vblank = (r_v >= c_v_act);

    always_comb begin
        w_cur = '0;
        case (w_idx)
            3'd0:    w_cur = {28'd0, r_irq_en, r_mode, r_en};
            3'd1:    w_cur = 32'(r_bg);
            3'd2:    w_cur = {5'd0, r_box_y, 5'd0, r_box_x};
            3'd3:    w_cur = {24'd0, r_box_size};
            3'd4:    w_cur = 32'(r_box_col);
            3'd5:    w_cur = {r_frame, 14'd0, r_irq_pend, w_vblank};
            default: w_cur = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_en       <= 1'b0;
            r_mode     <= '0;
            r_irq_en   <= 1'b0;
            r_bg       <= '0;
            r_box_col  <= '0;
            r_box_x    <= '0;
            r_box_y    <= '0;
            r_box_size <= '0;
            r_irq_pend <= 1'b0;
            r_inta     <= 1'b0;
            r_frame    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= '0;
        end else begin
            r_ack  <= w_req & w_adr_ok;
            r_err  <= w_req & ~w_adr_ok;
            r_dat  <= (w_req & w_adr_ok) ? w_cur : 32'd0;
            r_inta <= r_irq_pend & r_irq_en;
            if (w_wr) begin
                case (w_idx)
                    3'd0: begin
                        r_en     <= w_wdat[0];
                        r_mode   <= w_wdat[2:1];
                        r_irq_en <= w_wdat[3];
                    end
                    3'd1:    r_bg       <= c_cw'(w_wdat);
                    3'd2: begin
                        r_box_x <= 11'(w_wdat);
                        r_box_y <= 11'(w_wdat >> 16);
                    end
                    3'd3:    r_box_size <= 8'(w_wdat);
                    3'd4:    r_box_col  <= c_cw'(w_wdat);
                    default: ;
                endcase
            end
            // A vblank-start set takes priority over a simultaneous W1C
            if (w_vb_start) begin
                r_irq_pend <= 1'b1;
                r_frame    <= r_frame + 16'd1;
            end else if (w_wr && (w_idx == 3'd5) && w_w1c) begin
                r_irq_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Active drawing set
    // ------------------------------------------------------------------
`ifdef VGA_SHADOW_EN
    logic [c_cw-1:0] r_act_bg, r_act_box_col;
    logic [10:0]     r_act_x, r_act_y;
    logic [7:0]      r_act_size;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_act_bg      <= '0;
            r_act_box_col <= '0;
            r_act_x       <= '0;
            r_act_y       <= '0;
            r_act_size    <= '0;
        end else if (w_vb_start) begin
            r_act_bg      <= r_bg;
            r_act_box_col <= r_box_col;
            r_act_x       <= r_box_x;
            r_act_y       <= r_box_y;
            r_act_size    <= r_box_size;
        end
    end

    assign w_act_bg      = r_act_bg;
    assign w_act_box_col = r_act_box_col;
    assign w_act_x       = r_act_x;
    assign w_act_y       = r_act_y;
    assign w_act_size    = r_act_size;
`else
    assign w_act_bg      = r_bg;
    assign w_act_box_col = r_box_col;
    assign w_act_x       = r_box_x;
    assign w_act_y       = r_box_y;
    assign w_act_size    = r_box_size;
`endif

    // ------------------------------------------------------------------
    // Timing and pixel generation
    // ------------------------------------------------------------------
    assign w_pix_en   = r_en & (r_div == c_div_last);
    assign w_h_wrap   = (r_h == c_h_last);
    assign w_vb_start = w_pix_en & w_h_wrap & (r_v == c_v_vb);
    assign w_active   = (r_h < c_h_act) && (r_v < c_v_act);
    assign w_hs_on    = (r_h >= c_hs_beg) && (r_h < c_hs_end);
    assign w_vs_on    = (r_v >= c_vs_beg) && (r_v < c_vs_end);

    assign w_bar     = r_h / c_bar_w;
    assign w_bar_idx = (w_bar > c_hw'(7)) ? 3'd7 : w_bar[2:0];

    assign w_bx0    = c_hw'(w_act_x);
    assign w_bx1    = c_hw'(12'({1'b0, w_act_x}) + 12'(w_act_size));
    assign w_by0    = c_vw'(w_act_y);
    assign w_by1    = c_vw'(12'({1'b0, w_act_y}) + 12'(w_act_size));
    assign w_in_box = (r_h >= w_bx0) && (r_h < w_bx1) && (r_v >= w_by0) && (r_v < w_by1);

    always_comb begin
        w_pix = '0;
        if (w_active) begin
            case (r_mode)
                2'd0:    w_pix = w_act_bg;
                2'd1:    w_pix = {{COLOR_W{w_bar_idx[2]}}, {COLOR_W{w_bar_idx[1]}},
                                  {COLOR_W{w_bar_idx[0]}}};
                2'd2:    w_pix = (r_h[3] ^ r_v[3]) ? w_act_bg : '0;
                default: w_pix = w_in_box ? w_act_box_col : w_act_bg;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
            r_hs  <= c_sync_off;
            r_vs  <= c_sync_off;
        end else if (!r_en) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
            r_hs  <= c_sync_off;
            r_vs  <= c_sync_off;
        end else begin
            r_div <= w_pix_en ? '0 : r_div + 1'b1;
            if (w_pix_en) begin
                r_h <= w_h_wrap ? '0 : r_h + 1'b1;
                if (w_h_wrap) begin
                    r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
                end
                // Outputs lag the counters by exactly one pixel
                r_red <= w_pix[c_cw-1 -: COLOR_W];
                r_grn <= w_pix[2*COLOR_W-1 -: COLOR_W];
                r_blu <= w_pix[COLOR_W-1:0];
                r_hs  <= w_hs_on ? SYNC_POL : c_sync_off;
                r_vs  <= w_vs_on ? SYNC_POL : c_sync_off;
            end
        end
    end

    assign wb_dat_o  = r_dat;
    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_inta_o = r_inta;
    assign VGA_R_LED = r_red;
    assign VGA_G_LED = r_grn;
    assign VGA_B_LED = r_blu;
    assign VGA_HSYNC = r_hs;
    assign VGA_VSYNC = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_wb
// Brief    : Directed self-checking bench for vga_timing_wb on a reduced
//            80x30-pixel frame (64x24 visible, 2 clocks per pixel).
// Revision : 1.0
// ============================================================================
module tb_vga_timing_wb;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 24;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int COLOR_W  = 4;
    localparam int H_TOT    = 80;
    localparam int V_TOT    = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_wdat = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_rdat;
    logic        wb_ack, wb_err, wb_inta;
    logic [COLOR_W-1:0] vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;
    logic [11:0] rgb;

    int cyc_cnt  = 0;
    int t0       = 0;
    int last_ack = 0;
    int n_checks = 0;
    int n_pass   = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_timing_wb #(
        .CLK_DIV (CLK_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
        .H_BP    (H_BP),     .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
        .V_BP    (V_BP),     .COLOR_W (COLOR_W),  .SYNC_POL(1'b0)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_wdat),
        .wb_sel_i (wb_sel),
        .wb_dat_o (wb_rdat),
        .wb_ack_o (wb_ack),
        .wb_err_o (wb_err),
        .wb_inta_o(wb_inta),
        .VGA_R_LED(vga_r),
        .VGA_G_LED(vga_g),
        .VGA_B_LED(vga_b),
        .VGA_HSYNC(vga_hs),
        .VGA_VSYNC(vga_vs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc_cnt);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Clock edge on which pixel (h,v) of frame f appears on the outputs
    function automatic int pix_t(input int f, input int h, input int v);
        return t0 + ((f * V_TOT + v) * H_TOT + h + 1) * CLK_DIV;
    endfunction

    // Clock edge on which frame f enters vblank
    function automatic int vb_edge(input int f);
        return t0 + (f * V_TOT + V_ACTIVE) * H_TOT * CLK_DIV;
    endfunction

    task automatic wait_to(input int t);
        if (cyc_cnt > t) check("late", cyc_cnt, t);
        while (cyc_cnt < t) @(negedge clk);
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat,
                           output logic ack, output logic err);
        int n;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr;  wb_wdat = dat; wb_sel = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb_ack || wb_err) && n < 8);
        ack = wb_ack; err = wb_err; rdat = wb_rdat;
        last_ack = cyc_cnt;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!(ack || err)) check("bus_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("resp_width", {30'd0, wb_ack, wb_err}, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        logic a, e;
        wb_xfer(1'b1, adr, dat, 4'hF, rd, a, e);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
        logic a, e;
        wb_xfer(1'b0, adr, 32'd0, 4'hF, rd, a, e);
    endtask

    initial begin
        logic [31:0] rd;
        logic a, e;
        int lows;

        // Reset values
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rgb", rgb, 12'h000);
        check("rst_hs", vga_hs, 1'b1);
        check("rst_vs", vga_vs, 1'b1);
        check("rst_ack_err_inta", {wb_ack, wb_err, wb_inta}, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("dat_idle", wb_rdat, 32'd0);

        // Bus: byte enables and error termination
        wb_xfer(1'b1, 32'h04, 32'h0000_0FFF, 4'b0001, rd, a, e);
        wb_read(32'h04, rd);
        check("bg_sel0", rd, 32'h0FF);
        wb_xfer(1'b1, 32'h04, 32'h0000_0A00, 4'b0010, rd, a, e);
        wb_read(32'h04, rd);
        check("bg_sel1", rd, 32'hAFF);
        wb_xfer(1'b0, 32'h18, 32'd0, 4'hF, rd, a, e);
        check("err18_ack_err", {a, e}, 2'b01);
        wb_xfer(1'b1, 32'h1C, 32'hFFFF_FFFF, 4'hF, rd, a, e);
        check("err1c_ack_err", {a, e}, 2'b01);
        wb_read(32'h14, rd);
        check("status_idle", rd, 32'd0);
        wb_write(32'h04, 32'h0);

        // Timing
        wb_write(32'h00, 32'h1);
        t0 = last_ack;
        wait_to(pix_t(0, 67, 0)); check("hs_before", vga_hs, 1'b1);
        wait_to(pix_t(0, 68, 0)); check("hs_first", vga_hs, 1'b0);
        wait_to(pix_t(0, 75, 0)); check("hs_last", vga_hs, 1'b0);
        wait_to(pix_t(0, 76, 0)); check("hs_after", vga_hs, 1'b1);
        wait_to(pix_t(0, 0, 1));
        lows = 0;
        for (int i = 0; i < H_TOT * CLK_DIV; i++) begin
            if (!vga_hs) lows++;
            @(negedge clk);
        end
        check("hs_low_clocks", lows, H_SYNC * CLK_DIV);
        wait_to(pix_t(0, 79, 25)); check("vs_before", vga_vs, 1'b1);
        wait_to(pix_t(0, 0, 26));  check("vs_first", vga_vs, 1'b0);
        wait_to(pix_t(0, 79, 27)); check("vs_last", vga_vs, 1'b0);
        wait_to(pix_t(0, 0, 28));  check("vs_after", vga_vs, 1'b1);
        wait_to(pix_t(1, 79, 25)); check("vs_f1_before", vga_vs, 1'b1);
        wait_to(pix_t(1, 0, 26));  check("vs_f1_first", vga_vs, 1'b0);
        wait_to(pix_t(1, 0, 27));
        wb_read(32'h14, rd);
        check("status_2frames", rd, 32'h0002_0003);

        // Colour bars
        wb_write(32'h00, 32'h3);
        wait_to(pix_t(2, 0, 3));  check("bar0", rgb, 12'h000);
        wait_to(pix_t(2, 8, 3));  check("bar1", rgb, 12'h00F);
        wait_to(pix_t(2, 16, 3)); check("bar2", rgb, 12'h0F0);
        wait_to(pix_t(2, 56, 3)); check("bar7", rgb, 12'hFFF);
        wait_to(pix_t(2, 63, 3)); check("bar7_end", rgb, 12'hFFF);
        wait_to(pix_t(2, 64, 3)); check("bar_porch", rgb, 12'h000);

        // Checkerboard
        wait_to(pix_t(2, 0, 25));
        wb_write(32'h04, 32'hABC);
        wb_write(32'h00, 32'h5);
        wait_to(pix_t(3, 0, 0)); check("chk_00", rgb, 12'h000);
        wait_to(pix_t(3, 8, 0)); check("chk_80", rgb, 12'hABC);
        wait_to(pix_t(3, 0, 8)); check("chk_08", rgb, 12'hABC);
        wait_to(pix_t(3, 8, 8)); check("chk_88", rgb, 12'h000);

        // Box
        wait_to(pix_t(3, 0, 25));
        wb_write(32'h04, 32'h00F);
        wb_write(32'h10, 32'hF00);
        wb_write(32'h08, (32'd5 << 16) | 32'd10);
        wb_write(32'h0C, 32'd4);
        wb_write(32'h00, 32'h7);
        wait_to(pix_t(4, 10, 4)); check("box_above", rgb, 12'h00F);
        wait_to(pix_t(4, 9, 5));  check("box_left", rgb, 12'h00F);
        wait_to(pix_t(4, 10, 5)); check("box_tl", rgb, 12'hF00);
        wait_to(pix_t(4, 13, 8)); check("box_br", rgb, 12'hF00);
        wait_to(pix_t(4, 14, 8)); check("box_right", rgb, 12'h00F);
        wait_to(pix_t(4, 10, 9)); check("box_below", rgb, 12'h00F);
        wait_to(pix_t(4, 0, 25));
        wb_write(32'h08, (32'd5 << 16) | 32'd62);
        wait_to(pix_t(5, 61, 6)); check("clip_left", rgb, 12'h00F);
        wait_to(pix_t(5, 62, 6)); check("clip_in0", rgb, 12'hF00);
        wait_to(pix_t(5, 63, 6)); check("clip_in1", rgb, 12'hF00);
        wait_to(pix_t(5, 64, 6)); check("clip_edge", rgb, 12'h000);

        // Interrupt
        wait_to(pix_t(5, 0, 25));
        wb_write(32'h14, 32'h2);
        wb_write(32'h00, 32'hF);
        check("inta_cleared", wb_inta, 1'b0);
        wb_read(32'h00, rd);
        check("ctrl_rb", rd, 32'hF);
        wait_to(vb_edge(6));     check("inta_pre", wb_inta, 1'b0);
        wait_to(vb_edge(6) + 1); check("inta_rise", wb_inta, 1'b1);
        wait_to(pix_t(6, 0, 26));
        wb_write(32'h14, 32'h2);
        check("inta_w1c", wb_inta, 1'b0);
        wb_read(32'h14, rd);
        check("pend_w1c", rd[1], 1'b0);
        wait_to(vb_edge(7) - 1);
        wb_write(32'h14, 32'h2);
        wb_read(32'h14, rd);
        check("pend_set_wins", rd[1], 1'b1);
        check("inta_set_wins", wb_inta, 1'b1);
        wb_write(32'h14, 32'h2);
        check("inta_later_clr", wb_inta, 1'b0);

        // Asynchronous reset mid-frame
        wait_to(pix_t(8, 5, 12));
        check("pre_rst_rgb", rgb, 12'h00F);
        #1 rst = 1'b1;
        #1;
        check("arst_rgb", rgb, 12'h000);
        check("arst_sync", {vga_hs, vga_vs}, 2'b11);
        check("arst_inta", wb_inta, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wb_read(32'h04, rd);
        check("arst_bg", rd, 32'd0);
        wb_write(32'h04, 32'h123);
        wb_write(32'h00, 32'h1);
        t0 = last_ack;
        wait_to(pix_t(0, 0, 0));  check("restart_px0", rgb, 12'h123);
        wait_to(pix_t(0, 67, 0)); check("restart_hs_off", vga_hs, 1'b1);
        wait_to(pix_t(0, 68, 0)); check("restart_hs_on", vga_hs, 1'b0);
        wait_to(pix_t(0, 10, 1)); check("restart_line1", rgb, 12'h123);
        wb_write(32'h00, 32'h0);
        check("en_clear_rgb", rgb, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_wb.md
Name: vga_timing_wb

Overview:
- Parametrised VGA timing and pixel generator with a Wishbone slave register interface; successor to the fixed-mode VGA block.
- Runs entirely on the Wishbone clock and derives the pixel rate with an internal clock-enable divider, so there is no second clock domain.
- Generates HSYNC/VSYNC and RGB from programmable modes: solid background, colour bars, checkerboard, or a movable box over the background.
- Raises an interrupt at vblank start so software can update state tear-free.

Parameters:
- CLK_DIV, 4, wb_clk_i cycles per pixel (>=1); 100 MHz gives 25 MHz pixels.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- COLOR_W, 4, bits per colour channel (1..8).
- SYNC_POL, 0, sync active level (0 = active-low).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only [4:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables for writes.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_inta_o  out  1  interrupt request.
- VGA_R_LED  out  COLOR_W  red.
- VGA_G_LED  out  COLOR_W  green.
- VGA_B_LED  out  COLOR_W  blue.
- VGA_HSYNC  out  1  horizontal sync.
- VGA_VSYNC  out  1  vertical sync.

Behaviour:
- Reset is asynchronous and active-high: wb_clk_i is the only clock, wb_rst_i the asynchronous active-high reset. On reset:
  - all registers and counters clear to 0; RGB = 0;
  - syncs go to the inactive level (~SYNC_POL);
  - wb_ack_o, wb_err_o and wb_inta_o = 0.
- Pixel enable:
  - pix_en pulses one cycle every CLK_DIV clocks via a divider counter.
  - The divider runs only while CTRL.EN = 1; clearing EN resets the divider, h_cnt and v_cnt to 0 and forces RGB = 0 and syncs inactive on the next clock.
- Counters:
  - On pix_en, h_cnt increments and wraps at H_TOT-1 (H_TOT = sum of the four H_* parameters).
  - On h wrap, v_cnt increments and wraps at V_TOT-1.
- Sync:
  - hsync active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync active by the same rule on v_cnt.
- Outputs: RGB and syncs are registered on pix_en from the current counts, so all outputs are mutually aligned with a fixed one-pixel lag. RGB = 0 outside the active area.
- CTRL.MODE selects the pixel source:
  - 0: BG_COLOR.
  - 1: eight vertical bars, width H_ACTIVE/8. Bar index b gives R=b[2], G=b[1], B=b[0], each replicated to full scale.
  - 2: 8x8-pixel checkerboard, h_cnt[3]^v_cnt[3]; BG_COLOR when 1, black when 0.
  - 3: BOX_COLOR when X <= h_cnt < X+SIZE and Y <= v_cnt < Y+SIZE, else BG_COLOR. The box is clipped at the screen edge; X/Y beyond the active area means no box is drawn.
- Register map (word offsets, reads zero-fill unused bits):
  - 0x00 CTRL: [0] EN, [2:1] MODE, [3] IRQ_EN.
  - 0x04 BG_COLOR: [3*COLOR_W-1:0] {R,G,B}.
  - 0x08 BOX_POS: [10:0] X, [26:16] Y.
  - 0x0C BOX_SIZE: [7:0] SIZE.
  - 0x10 BOX_COLOR: as BG_COLOR.
  - 0x14 STATUS (read-only except bit 1): [0] vblank, [1] IRQ_PEND (W1C), [31:16] frame counter (wraps at 0xFFFF, increments at vblank start).
- Wishbone handshake:
  - When cyc & stb & !ack, the slave responds on the next clock with a single-cycle ack (offsets 0x00-0x14) or err (offsets 0x18-0x1C); one or the other, never both.
  - Writes honour wb_sel_i per byte; an errored access writes nothing.
  - wb_dat_o is valid with ack and 0 otherwise.
  - Back-to-back strobes are served every second cycle.
- Interrupt:
  - IRQ_PEND sets on the pix_en where v_cnt moves to V_ACTIVE (vblank start).
  - A set and a W1C clear in the same cycle: set wins.
  - wb_inta_o = IRQ_PEND & IRQ_EN, registered.
- Register writes and vblank events in the same cycle are independent; there is no stall.

Optional Feature:
- VGA_SHADOW_EN defined: BG_COLOR, BOX_POS, BOX_SIZE and BOX_COLOR are double-buffered. Writes go to the shadow copy, which is copied to the active set on the pix_en of vblank start, so a frame never tears. Reads return the shadow copy.
- Not defined: writes take effect on the next pix_en.

Test Plan:
- Timing: reset, write CTRL=0x1, run two frames -> HSYNC low for 96 pixels (384 clocks) every 800 pixels; VSYNC low for 2 lines every 525 lines; frame counter reads 2.
- Bars: MODE=1 -> pixel 0 = (0,0,0), pixel 80 = (0,0,F), pixel 560 = (F,F,F).
- Box:
  - MODE=3, BG=0x00F, BOX_COLOR=0xF00, X=100, Y=50, SIZE=16 -> red exactly at h 100..115, v 50..65; blue elsewhere in the active area.
  - X=630 -> box clipped at h=639.
- Bus:
  - Write 0x04 with sel=0001, data 0xFFF -> readback 0x0FF.
  - Access 0x18 -> err=1, ack=0.
  - Every ack/err is one cycle wide.
- IRQ: IRQ_EN=1 -> inta rises at the vblank start. W1C of 0x2 issued on the vblank-start cycle -> pending stays 1. A later clear -> inta=0.
- Reset mid-frame: assert wb_rst_i asynchronously at line 200 -> outputs reset without waiting for a clock edge; after release with EN=1 the counting restarts at (0,0).
